// File: rtl/masked_pkg.sv
// masked_pkg: shared FSM states, bit timing and randomness sizing for masked serial arithmetic
package masked_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int T_BIT = 2;
  function automatic int rnd_w(input int n);
    return n * (n - 1) / 2;
  endfunction
endpackage

// File: rtl/masked_sub_serial_if.sv
// masked_sub_serial_if: operand/result handshake bus for the masked serial subtractor
interface masked_sub_serial_if #(parameter int d = 2, parameter int W = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [d*W-1:0]       a_input;
  logic [d*W-1:0]       b_input;
  logic [d*(d-1)-1:0]   rnd;
  logic                 out_valid;
  logic                 out_ready;
  logic [d*(W+1)-1:0]   out_c;
  modport master (output in_valid, a_input, b_input, rnd, out_ready, input in_ready, out_valid, out_c);
  modport slave (input in_valid, a_input, b_input, rnd, out_ready, output in_ready, out_valid, out_c);
endinterface

// File: rtl/MSKand_HPC2.sv
// MSKand_HPC2: d-share HPC2 AND gadget; inb sampled in cycle 0, ina held through cycle 1, c valid in cycle 1
module MSKand_HPC2 import masked_pkg::*; #(parameter int d = 2) (
  input  logic                  clk,
  input  logic [d-1:0]          ina,
  input  logic [d-1:0]          inb,
  input  logic [rnd_w(d)-1:0]   rnd,
  output logic [d-1:0]          c
);
  for (genvar i = 0; i < d; i++) begin : g_i
    logic aibi;
    logic [d-1:0] t;
    always_ff @(posedge clk) aibi <= ina[i] & inb[i];
    for (genvar j = 0; j < d; j++) begin : g_j
      if (i == j) begin : g_eq
        assign t[j] = 1'b0;
      end else begin : g_ne
        localparam int lo = i < j ? i : j;
        localparam int hi = i < j ? j : i;
        // r_ij == r_ji so the cross terms cancel when all shares are combined
        localparam int k = lo * d - lo * (lo + 1) / 2 + hi - lo - 1;
        logic u, v;
        always_ff @(posedge clk) begin
          u <= ~ina[i] & rnd[k];
          v <= inb[j] ^ rnd[k];
        end
        assign t[j] = u ^ (ina[i] & v);
      end
    end
    assign c[i] = aibi ^ (^t);
  end
endmodule

// File: rtl/masked_fsub_bit.sv
// masked_fsub_bit: one masked full-subtractor slice; borrow-out valid one cycle after inputs settle
module masked_fsub_bit import masked_pkg::*; #(parameter int d = 2) (
  input  logic                    clk,
  input  logic [d-1:0]            a,
  input  logic [d-1:0]            b,
  input  logic [d-1:0]            br,
  input  logic [2*rnd_w(d)-1:0]   rnd,
  output logic [d-1:0]            diff,
  output logic [d-1:0]            br_next
);
  localparam int R = rnd_w(d);
  localparam logic [d-1:0] INV = {{(d-1){1'b0}}, 1'b1};
  logic [d-1:0] x, t0, t1;
  assign x = a ^ b;
  assign diff = x ^ br;
  MSKand_HPC2 #(.d(d)) u_and0 (.clk(clk), .ina(a ^ INV), .inb(b), .rnd(rnd[R-1:0]), .c(t0));
  MSKand_HPC2 #(.d(d)) u_and1 (.clk(clk), .ina(x ^ INV), .inb(br), .rnd(rnd[2*R-1:R]), .c(t1));
  assign br_next = t0 ^ t1;
endmodule

// File: rtl/masked_sub_serial.sv
// masked_sub_serial: bit-serial share-wise a - b with borrow, LSB first, two cycles per bit
module masked_sub_serial import masked_pkg::*; #(parameter int d = 2, parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  masked_sub_serial_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam int PW = $clog2(T_BIT);
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] phase;
  logic [d*W-1:0] a_sh, b_sh, c_sh;
  logic [d-1:0] br, diff, br_nx;
  masked_fsub_bit #(.d(d)) u_bit (
    .clk(clk), .a(a_sh[d-1:0]), .b(b_sh[d-1:0]), .br(br), .rnd(bus.rnd), .diff(diff), .br_next(br_nx)
  );
  assign bus.out_c = {br, c_sh};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      cnt <= '0;
      phase <= '0;
      a_sh <= '0;
      b_sh <= '0;
      c_sh <= '0;
      br <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sh <= bus.a_input;
          b_sh <= bus.b_input;
          br <= '0;
          cnt <= '0;
          phase <= '0;
          bus.in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: if (phase != PW'(T_BIT - 1)) phase <= phase + 1'b1;
        else begin
          phase <= '0;
          a_sh <= a_sh >> d;
          b_sh <= b_sh >> d;
          c_sh <= {diff, c_sh[d*W-1:d]};
          br <= br_nx;
          if (cnt == CW'(W - 1)) begin
            bus.out_valid <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + 1'b1;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
